// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//
// Loads instruction memory over the fetch stage's bootloader write port.
// It parses a framed byte stream from the UART receiver:
//   MAGIC, CNT_LO, CNT_HI, 4*N data bytes (little-endian words), CHK
// where CHK is the XOR of the count bytes and all data bytes. The core is
// held in reset until a frame completes with a matching checksum.
//
// Ports:
//   clk        in   system clock, all state changes on posedge
//   rst_n      in   asynchronous active-low reset
//   rx_data    in   received byte, valid when rx_valid
//   rx_valid   in   one-cycle strobe per received byte
//   boot_req   in   one-cycle request to return to IDLE from any state
//   debug      out  one-cycle instruction-memory write strobe
//   data_cpu   out  word to write
//   waddr_cpu  out  word index, bits [31:16] always zero
//   cpu_rst_n  out  core reset, active-low, released only in DONE
//   boot_done  out  high in DONE
//   boot_err   out  high in ERR

module imem_boot_loader #(
    parameter logic [7:0]  MAGIC          = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        boot_req,
    output logic        debug,
    output logic [31:0] data_cpu,
    output logic [31:0] waddr_cpu,
    output logic        cpu_rst_n,
    output logic        boot_done,
    output logic        boot_err
);

    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCntLo,
        StCntHi,
        StData,
        StChk,
        StDone,
        StErr
    } state_e;

    state_e          state_q;
    logic [15:0]     word_cnt_q;  // N from the frame header
    logic [15:0]     word_idx_q;  // index of the word being assembled
    logic [1:0]      byte_cnt_q;  // byte position within the current word
    logic [31:0]     asm_q;       // shift register, newest byte enters at [31:24]
    logic [7:0]      chk_q;       // running XOR
    logic [TmoW-1:0] tmo_cnt_q;   // idle cycles since the last accepted byte

    logic            is_magic;
    logic            timed;
    logic [15:0]     hdr_cnt;

    assign is_magic = rx_valid && (rx_data == MAGIC);
    assign hdr_cnt  = {rx_data, word_cnt_q[7:0]};
    // Inter-byte timeout only applies while a frame is in progress.
    assign timed    = (state_q == StCntLo) || (state_q == StCntHi) ||
                      (state_q == StData)  || (state_q == StChk);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            word_cnt_q <= 16'h0;
            word_idx_q <= 16'h0;
            byte_cnt_q <= 2'd0;
            asm_q      <= 32'h0;
            chk_q      <= 8'h0;
            tmo_cnt_q  <= '0;
            debug      <= 1'b0;
            data_cpu   <= 32'h0;
            waddr_cpu  <= 32'h0;
            cpu_rst_n  <= 1'b0;
            boot_done  <= 1'b0;
            boot_err   <= 1'b0;
        end else begin
            debug <= 1'b0;

            if (boot_req) begin
                // Takes priority over any byte arriving in the same cycle.
                state_q    <= StIdle;
                byte_cnt_q <= 2'd0;
                tmo_cnt_q  <= '0;
                cpu_rst_n  <= 1'b0;
                boot_done  <= 1'b0;
                boot_err   <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (is_magic) begin
                            state_q    <= StCntLo;
                            chk_q      <= 8'h0;
                            word_idx_q <= 16'h0;
                            byte_cnt_q <= 2'd0;
                        end
                    end

                    StCntLo: begin
                        if (rx_valid) begin
                            word_cnt_q[7:0] <= rx_data;
                            chk_q           <= chk_q ^ rx_data;
                            state_q         <= StCntHi;
                        end
                    end

                    StCntHi: begin
                        if (rx_valid) begin
                            word_cnt_q <= hdr_cnt;
                            chk_q      <= chk_q ^ rx_data;
                            state_q    <= (hdr_cnt == 16'h0) ? StChk : StData;
                        end
                    end

                    StData: begin
                        if (rx_valid) begin
                            chk_q <= chk_q ^ rx_data;
                            asm_q <= {rx_data, asm_q[31:8]};
                            if (byte_cnt_q == 2'd3) begin
                                data_cpu   <= {rx_data, asm_q[31:8]};
                                waddr_cpu  <= {16'h0, word_idx_q};
                                debug      <= 1'b1;
                                byte_cnt_q <= 2'd0;
                                // Max index is 0xFFFE, so the increment never wraps.
                                word_idx_q <= word_idx_q + 16'd1;
                                if (word_idx_q == word_cnt_q - 16'd1) begin
                                    state_q <= StChk;
                                end
                            end else begin
                                byte_cnt_q <= byte_cnt_q + 2'd1;
                            end
                        end
                    end

                    StChk: begin
                        if (rx_valid) begin
                            if (rx_data == chk_q) begin
                                state_q   <= StDone;
                                cpu_rst_n <= 1'b1;
                                boot_done <= 1'b1;
                            end else begin
                                state_q  <= StErr;
                                boot_err <= 1'b1;
                            end
                        end
                    end

                    StDone: begin
                        // Only boot_req or rst_n leave DONE.
                    end

                    StErr: begin
                        if (is_magic) begin
                            state_q    <= StCntLo;
                            boot_err   <= 1'b0;
                            chk_q      <= 8'h0;
                            word_idx_q <= 16'h0;
                            byte_cnt_q <= 2'd0;
                        end
                    end

                    default: state_q <= StIdle;
                endcase

                // Overrides the byte handling above when the frame has stalled.
                if (timed && !rx_valid) begin
                    if (tmo_cnt_q == TmoLast) begin
                        state_q   <= StErr;
                        boot_err  <= 1'b1;
                        tmo_cnt_q <= '0;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end else begin
                    tmo_cnt_q <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: stimulus pushes expected writes,
// a negedge monitor pops and compares on every debug strobe.

module tb_imem_boot_loader;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        boot_req;
    logic        debug;
    logic [31:0] data_cpu;
    logic [31:0] waddr_cpu;
    logic        cpu_rst_n;
    logic        boot_done;
    logic        boot_err;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_q[$];  // {waddr, data}
    logic        prev_debug = 1'b0;

    imem_boot_loader #(
        .MAGIC          (8'hA5),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .boot_req  (boot_req),
        .debug     (debug),
        .data_cpu  (data_cpu),
        .waddr_cpu (waddr_cpu),
        .cpu_rst_n (cpu_rst_n),
        .boot_done (boot_done),
        .boot_err  (boot_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && debug) begin
            check("debug_not_adjacent", {31'b0, prev_debug}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", waddr_cpu, 32'hFFFF_FFFF);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("write_addr", waddr_cpu, e[63:32]);
                check("write_data", data_cpu, e[31:0]);
            end
        end
        prev_debug = debug;
    end

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic req_boot();
        boot_req = 1'b1;
        @(posedge clk);
        #1;
        boot_req = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic rn, input logic dn,
                                input logic er);
        check({tag, "_cpu_rst_n"}, {31'b0, cpu_rst_n}, {31'b0, rn});
        check({tag, "_boot_done"}, {31'b0, boot_done}, {31'b0, dn});
        check({tag, "_boot_err"},  {31'b0, boot_err},  {31'b0, er});
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        boot_req = 1'b0;

        // Reset state
        #12;
        check("rst_debug", {31'b0, debug}, 32'd0);
        check("rst_data", data_cpu, 32'h0);
        check("rst_waddr", waddr_cpu, 32'h0);
        check_status("rst", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load one word
        exp_q.push_back({32'd0, 32'h0000_0013});
        send(8'hA5); send(8'h01); send(8'h00);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        check_status("one_pre_chk", 1'b0, 1'b0, 1'b0);
        send(8'h12);
        check_status("one_done", 1'b1, 1'b1, 1'b0);

        // boot_req from DONE with a MAGIC byte in the same cycle: byte dropped
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        req_boot();
        rx_valid = 1'b0;
        check_status("req_idle", 1'b0, 1'b0, 1'b0);
        // Without a header this payload must be ignored in IDLE.
        send(8'h01); send(8'h00); send(8'h13); send(8'h00);
        send(8'h00); send(8'h00); send(8'h12);
        check_status("req_dropped", 1'b0, 1'b0, 1'b0);

        // Checksum error then recovery via MAGIC from ERR
        exp_q.push_back({32'd0, 32'h0000_0013});
        send(8'hA5); send(8'h01); send(8'h00);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        send(8'h00);
        check_status("chk_err", 1'b0, 1'b0, 1'b1);
        exp_q.push_back({32'd0, 32'h1234_5678});
        send(8'hA5);
        check_status("err_restart", 1'b0, 1'b0, 1'b0);
        send(8'h01); send(8'h00);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        send(8'h09);
        check_status("recover_done", 1'b1, 1'b1, 1'b0);

        // Noise before MAGIC and a zero-length frame
        req_boot();
        send(8'h00); send(8'hFF); send(8'hA5); send(8'h00); send(8'h00);
        check_status("zero_pre_chk", 1'b0, 1'b0, 1'b0);
        send(8'h00);
        check_status("zero_done", 1'b1, 1'b1, 1'b0);

        // Back-to-back three-word load
        req_boot();
        exp_q.push_back({32'd0, 32'hDEAD_BEEF});
        exp_q.push_back({32'd1, 32'h0102_0304});
        exp_q.push_back({32'd2, 32'hCAFE_F00D});
        send(8'hA5); send(8'h03); send(8'h00);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        send(8'h04); send(8'h03); send(8'h02); send(8'h01);
        send(8'h0D); send(8'hF0); send(8'hFE); send(8'hCA);
        send(8'hEC);
        check_status("b2b_done", 1'b1, 1'b1, 1'b0);

        // Timeout: 16 idle edges after A5, 02
        req_boot();
        send(8'hA5); send(8'h02);
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            if (i == 15) check("tmo_edge15_err", {31'b0, boot_err}, 32'd0);
        end
        check_status("tmo_edge16", 1'b0, 1'b0, 1'b1);

        // Asynchronous reset after 2 of 4 data bytes
        send(8'hA5); send(8'h01); send(8'h00); send(8'h11); send(8'h22);
        check("pre_rst_data_held", data_cpu, 32'hCAFE_F00D);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_debug", {31'b0, debug}, 32'd0);
        check("midrst_data", data_cpu, 32'h0);
        check("midrst_waddr", waddr_cpu, 32'h0);
        check_status("midrst", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Remainder of the interrupted word must not produce a write.
        send(8'h33); send(8'h44); send(8'h67);
        check_status("post_rst", 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Sequencer for the fetch stage's instruction-memory bootloader write port. It consumes a framed byte stream from the UART receiver, assembles little-endian 32-bit words and drives `debug`/`data_cpu`/`waddr_cpu` one word at a time. It holds the core in reset (`cpu_rst_n`) until a frame has loaded with a valid checksum.

## Interface

- `MAGIC`, default 8'hA5: frame start byte.
- `TIMEOUT_CYCLES`, default 1_000_000: maximum idle cycles between bytes inside a frame.
- `clk`  in  1  system clock; all state changes on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte; valid only when `rx_valid`.
- `rx_valid`  in  1  single-cycle strobe, one per byte.
- `boot_req`  in  1  single-cycle request to re-enter loading from DONE or any state.
- `debug`  out  1  instruction-memory write strobe to fetch.
- `data_cpu`  out  32  word to write.
- `waddr_cpu`  out  32  word index; bits [31:16] always 0.
- `cpu_rst_n`  out  1  core reset, active-low; 0 except in DONE.
- `boot_done`  out  1  high in DONE.
- `boot_err`  out  1  high in ERR.

## Operation

- Frame format, in byte order:
  - `MAGIC`
  - CNT_LO, CNT_HI: N = 16-bit word count, 0..65535.
  - 4·N data bytes, little-endian per word: the first byte goes to [7:0].
  - CHK = XOR of CNT_LO, CNT_HI and all data bytes.
- States and transitions:
  - IDLE: a byte equal to `MAGIC` goes to CNT_LO. Other bytes are ignored.
  - CNT_LO → CNT_HI on the next byte.
  - CNT_HI: if N = 0, go to CHK; otherwise go to DATA.
  - DATA: shift bytes into the assembly register.
    - On the 4th byte of a word: register the word into `data_cpu` and the word index into `waddr_cpu`, and set `debug` = 1 for one cycle.
    - Then increment the index and reset the byte counter.
    - After word N−1 is issued, go to CHK.
  - CHK: if the byte equals the running XOR, go to DONE; otherwise go to ERR.
  - DONE: `cpu_rst_n` = 1, `boot_done` = 1. `rx_valid` is ignored.
  - ERR: `boot_err` = 1, `cpu_rst_n` = 0. A `MAGIC` byte restarts the frame (→ CNT_LO, `boot_err` clears).
- Word index starts at 0 for every frame. The running XOR and index clear on entry to CNT_LO.
- Timeout:
  - The counter resets on every accepted byte and counts only in CNT_LO, CNT_HI, DATA and CHK.
  - When TIMEOUT_CYCLES consecutive cycles pass with no `rx_valid`, go to ERR.
- `boot_req` (any state) → IDLE.
  - `cpu_rst_n` = 0; `boot_done` and `boot_err` clear; `debug` = 0.
  - A byte arriving in the same cycle is discarded (`boot_req` wins).
- Memory words not written keep their prior contents. The loader never clears memory.
- The core is not released on error or partial load.

## Timing

- Reset values:
  - `debug` = 0, `data_cpu` = 0, `waddr_cpu` = 0
  - `cpu_rst_n` = 0, `boot_done` = 0, `boot_err` = 0
  - state IDLE; all counters 0
- Write latency:
  - 4th data byte accepted at posedge k → `debug`, `data_cpu` and `waddr_cpu` valid from posedge k to posedge k+1.
  - Fetch writes on the intervening negedge.
  - `debug` drops at k+1; `data_cpu` and `waddr_cpu` hold until the next word.
- `debug` is never high for two consecutive cycles. Bytes may arrive back-to-back (`rx_valid` every cycle) with no loss.
- Correct CHK accepted at posedge k → `cpu_rst_n` = 1 and `boot_done` = 1 from posedge k.
- Bad CHK or timeout at posedge k → `boot_err` = 1 from posedge k.
- `rst_n` low mid-frame: all outputs go to reset values immediately. A partially assembled word is never written.
- N = 65535 → last write to index 0xFFFE. The index never wraps inside a frame.

## Test plan

- Load one word:
  - Stimulus: A5, 01, 00, 13, 00, 00, 00, CHK = 01^00^13 = 0x12.
  - Required: one `debug` pulse with `data_cpu` = 0x00000013 and `waddr_cpu` = 0, then `cpu_rst_n` = 1 and `boot_done` = 1.
- Checksum error, then recovery:
  - Stimulus: same frame with CHK = 0x00, then a correct frame.
  - Required: `boot_err` = 1 and `cpu_rst_n` stays 0 after the first frame; after the second, `boot_err` = 0 and `boot_done` = 1.
- Noise before magic and zero-length frame:
  - Stimulus: 00, FF, A5, 00, 00, 00.
  - Required: no `debug` pulses; DONE reached.
- Back-to-back multi-word load:
  - Stimulus: 3 words with `rx_valid` every cycle.
  - Required: `debug` pulses at indices 0, 1, 2, each with the correct little-endian word, never adjacent.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES = 16; after A5, 02, stall 16 cycles.
  - Required: `boot_err` = 1 on the 16th idle edge; no writes.
- Restart and reset mid-frame:
  - Stimulus: `boot_req` from DONE, together with `rx_valid` carrying A5.
  - Required: IDLE, `cpu_rst_n` = 0, byte dropped.
  - Stimulus: `rst_n` low after 2 of 4 data bytes.
  - Required: all outputs at reset values; no `debug` pulse.
